recirc_mux_tx_ctrl: RTL

Source-domain (clk1) transmitter for the recirculation-mux synchronizer. Accepts words from a valid/ready producer, then holds `tx_data` stable on the crossing. Drives `tx_en` as the crossing enable under a 4-phase level handshake, closed by the destination's acknowledge. The acknowledge is synchronized into clk1 internally. Sits between source logic and the clk2 recirculation-mux receiver.

---
 rtl/recirc_sync_pkg.sv | 13 +
 rtl/recirc_mux_tx_ctrl_bit_sync.sv | 23 ++
 rtl/recirc_mux_tx_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/recirc_sync_pkg.sv
// Shared types and constants for the recirculation-mux synchronizer.
// Used by both the clk1 transmitter and the clk2 receiver.
package recirc_sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/recirc_mux_tx_ctrl_bit_sync.sv
// Single-bit multi-flop synchronizer, async active-high reset to 0.
// Reusable on either side of the crossing.
module bit_sync
  import recirc_sync_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/recirc_mux_tx_ctrl.sv
// clk1-side transmitter: holds a word on the crossing and runs a
// 4-phase level handshake against the synchronized destination ack.
module recirc_mux_tx_ctrl
  import recirc_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk1,
  input  logic             rst_clk1,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  input  logic             ack_async,
  input  logic             err_clr,
  output logic             tx_en,
  output logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             timeout_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  tx_state_t       state, next;
  logic            ack_s;
  logic            accept;
  logic            to_hit;
  logic [CW-1:0]   cnt;

  bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk1),
    .rst (rst_clk1),
    .d   (ack_async),
    .q   (ack_s)
  );

  // Never accept into a stale ack left over from a previous transfer
  assign src_ready = (state == IDLE) && !ack_s;
  assign accept    = src_valid && src_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = REQ;
      REQ:     if (ack_s)  next = RELEASE;
      RELEASE: if (!ack_s) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst_clk1) begin
    if (rst_clk1) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= next;
      tx_en <= (next == REQ);
      if (accept) tx_data <= src_data;
    end
  end

  always_ff @(posedge clk1 or posedge rst_clk1) begin
    if (rst_clk1)           cnt <= '0;
    else if (next != state) cnt <= '0;
    else if (busy && cnt != TO_MAX)
      cnt <= cnt + 1'b1;
  end

  // Stays asserted while saturated, so a clear cannot beat a live set
  assign to_hit = (TIMEOUT != 0) && busy && (cnt == TO_MAX);

  always_ff @(posedge clk1 or posedge rst_clk1) begin
    if (rst_clk1)     timeout_err <= 1'b0;
    else if (to_hit)  timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

endmodule
